// File: rtl/alu_branch_exec_if.sv
// alu_branch_exec_if: operand, decode and result bundle between issue logic and the ALU/branch unit
interface alu_branch_exec_if;
   logic [2:0]  optype;
   logic [4:0]  control;
   logic [31:0] rn;
   logic [31:0] shifter;
   logic        shifter_carry;
   logic [23:0] branch_imm;
   logic        exec_valid;
   logic [3:0]  alu_opcode;
   logic [3:0]  should_set;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags;
   logic [3:0]  flags;
   logic        ib;
   logic        bl;
   logic [31:0] bv;
   modport master (
      output optype, control, rn, shifter, shifter_carry, branch_imm, exec_valid,
      input  alu_opcode, should_set, alu_out, alu_flags, flags, ib, bl, bv
   );
   modport slave (
      input  optype, control, rn, shifter, shifter_carry, branch_imm, exec_valid,
      output alu_opcode, should_set, alu_out, alu_flags, flags, ib, bl, bv
   );
endinterface

// File: rtl/alu_branch_exec.sv
// alu_branch_exec: data-processing ALU with NZCV flag register and branch target/take decode
module alu_branch_exec (
   input logic clk,
   input logic nreset,
   alu_branch_exec_if.slave bus
);
   logic        is_dp, is_ls, arith, rev, inv, cin, c, v;
   logic [3:0]  op, ss, af, fl, we;
   logic [31:0] a, b, res;
   logic [32:0] sum;
   // decode the ALU operation and which flags it may write
   always_comb begin
      is_dp = bus.optype[2:1] == 2'b00;
      is_ls = bus.optype[2:1] == 2'b01;
      op    = is_dp ? bus.control[4:1] : is_ls ? (bus.control[3] ? 4'h4 : 4'h2) : 4'hD;
      arith = (op >= 4'h2 && op <= 4'h7) || op == 4'hA || op == 4'hB;
      ss    = (is_dp && bus.control[0]) ? (arith ? 4'hF : 4'hE) : 4'h0;
   end
   // 33-bit adder: reverse forms swap operands, subtract forms invert the second operand
   always_comb begin
      rev = op == 4'h3 || op == 4'h7;
      inv = op == 4'h2 || op == 4'h6 || op == 4'hA;
      a   = rev ? bus.shifter : bus.rn;
      b   = rev ? ~bus.rn : inv ? ~bus.shifter : bus.shifter;
      cin = (op == 4'h5 || op == 4'h6 || op == 4'h7) ? fl[1] :
            (op == 4'h2 || op == 4'h3 || op == 4'hA);
      sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
   end
   // result mux and flag generation; logical ops take C from the shifter and keep V
   always_comb begin
      case (op)
         4'h0, 4'h8: res = bus.rn & bus.shifter;
         4'h1, 4'h9: res = bus.rn ^ bus.shifter;
         4'hC:       res = bus.rn | bus.shifter;
         4'hD:       res = bus.shifter;
         4'hE:       res = bus.rn & ~bus.shifter;
         4'hF:       res = ~bus.shifter;
         default:    res = sum[31:0];
      endcase
      c  = arith ? sum[32] : bus.shifter_carry;
      v  = arith ? (a[31] == b[31]) && (sum[31] != a[31]) : fl[0];
      af = {res[31], res == 32'd0, c, v};
      we = ss & {4{bus.exec_valid}};
   end
   // per-bit flag commit; unselected bits hold
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) fl <= 4'h0;
      else         fl <= (we & af) | (~we & fl);
   end
   assign bus.alu_opcode = op;
   assign bus.should_set = ss;
   assign bus.alu_out    = res;
   assign bus.alu_flags  = af;
   assign bus.flags      = fl;
   assign bus.ib         = bus.optype == 3'b101 && bus.exec_valid;
   assign bus.bl         = bus.ib && bus.control[4];
   assign bus.bv         = {{6{bus.branch_imm[23]}}, bus.branch_imm, 2'b00};
endmodule

// File: tb/tb_alu_branch_exec.sv
// tb_alu_branch_exec: directed vectors checked through an expectation queue
module tb_alu_branch_exec;
   logic clk, nreset;
   int   n_cmp, n_bad, idx;
   typedef struct {
      logic [3:0]  op, ss, af, fl;
      logic [31:0] out, bv;
      logic        ib, bl;
   } exp_t;
   exp_t q[$];
   alu_branch_exec_if bus ();
   alu_branch_exec dut (.clk(clk), .nreset(nreset), .bus(bus));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input int i, input string n, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL vec%0d %s: got %h expected %h", i, n, act, exp);
      end
   endtask
   task automatic apply(input logic [2:0] ot, input logic [4:0] ct, input logic [31:0] r, input logic [31:0] s,
                        input logic sc, input logic [23:0] im, input logic ev,
                        input logic [3:0] eop, input logic [3:0] ess, input logic [31:0] eout,
                        input logic [3:0] eaf, input logic [3:0] efl,
                        input logic eib, input logic ebl, input logic [31:0] ebv);
      exp_t e;
      @(posedge clk);
      #1;
      bus.optype = ot; bus.control = ct; bus.rn = r; bus.shifter = s;
      bus.shifter_carry = sc; bus.branch_imm = im; bus.exec_valid = ev;
      e.op = eop; e.ss = ess; e.out = eout; e.af = eaf; e.fl = efl;
      e.ib = eib; e.bl = ebl; e.bv = ebv;
      q.push_back(e);
   endtask
   // monitor: outputs are combinational, so each presented vector is checked mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk(idx, "alu_opcode", {28'd0, bus.alu_opcode}, {28'd0, e.op});
         chk(idx, "should_set", {28'd0, bus.should_set}, {28'd0, e.ss});
         chk(idx, "alu_out", bus.alu_out, e.out);
         chk(idx, "alu_flags", {28'd0, bus.alu_flags}, {28'd0, e.af});
         chk(idx, "flags", {28'd0, bus.flags}, {28'd0, e.fl});
         chk(idx, "ib", {31'd0, bus.ib}, {31'd0, e.ib});
         chk(idx, "bl", {31'd0, bus.bl}, {31'd0, e.bl});
         chk(idx, "bv", bus.bv, e.bv);
         idx++;
      end
   end
   initial begin
      n_cmp = 0; n_bad = 0; idx = 0;
      nreset = 0;
      bus.optype = 3'b100; bus.control = 5'h00; bus.rn = 0; bus.shifter = 0;
      bus.shifter_carry = 0; bus.branch_imm = 0; bus.exec_valid = 0;
      repeat (2) @(posedge clk);
      #1 nreset = 1;
      //     optype  ctl    rn            sh            sc  imm         ev   op    ss    out           af    fl    ib bl bv
      apply(3'b100, 5'h00, 32'h0,        32'h0,        0, 24'h000000, 0, 4'hD, 4'h0, 32'h0,        4'h4, 4'h0, 0, 0, 32'h0);
      apply(3'b000, 5'h05, 32'd5,        32'd5,        0, 24'h000000, 1, 4'h2, 4'hF, 32'h0,        4'h6, 4'h0, 0, 0, 32'h0);
      apply(3'b000, 5'h0B, 32'd1,        32'd1,        0, 24'h000000, 1, 4'h5, 4'hF, 32'd3,        4'h0, 4'h6, 0, 0, 32'h0);
      apply(3'b000, 5'h09, 32'h7FFFFFFF, 32'd1,        0, 24'h000000, 1, 4'h4, 4'hF, 32'h80000000, 4'h9, 4'h0, 0, 0, 32'h0);
      apply(3'b000, 5'h1B, 32'h0,        32'h0,        1, 24'h000000, 1, 4'hD, 4'hE, 32'h0,        4'h7, 4'h9, 0, 0, 32'h0);
      apply(3'b101, 5'h10, 32'h0,        32'h12345678, 0, 24'hFFFFFE, 1, 4'hD, 4'h0, 32'h12345678, 4'h1, 4'h7, 1, 1, 32'hFFFFFFF8);
      apply(3'b101, 5'h10, 32'h0,        32'h12345678, 0, 24'hFFFFFE, 0, 4'hD, 4'h0, 32'h12345678, 4'h1, 4'h7, 0, 0, 32'hFFFFFFF8);
      apply(3'b000, 5'h05, 32'd5,        32'd5,        0, 24'h000000, 0, 4'h2, 4'hF, 32'h0,        4'h6, 4'h7, 0, 0, 32'h0);
      apply(3'b010, 5'h00, 32'h100,      32'd4,        0, 24'h000000, 1, 4'h2, 4'h0, 32'hFC,       4'h2, 4'h7, 0, 0, 32'h0);
      apply(3'b011, 5'h08, 32'h100,      32'd4,        0, 24'h000000, 1, 4'h4, 4'h0, 32'h104,      4'h0, 4'h0, 0, 0, 32'h0);
      #2 nreset = 0;
      #4 nreset = 1;
      apply(3'b001, 5'h1D, 32'hFF00FF00, 32'hF0F0F0F0, 1, 24'h000000, 1, 4'hE, 4'hE, 32'h0F000F00,  4'h2, 4'h0, 0, 0, 32'h0);
      apply(3'b000, 5'h07, 32'd1,        32'd0,        0, 24'h000000, 1, 4'h3, 4'hF, 32'hFFFFFFFF, 4'h8, 4'h2, 0, 0, 32'h0);
      apply(3'b000, 5'h0D, 32'd10,       32'd3,        0, 24'h000000, 1, 4'h6, 4'hF, 32'd6,        4'h2, 4'h8, 0, 0, 32'h0);
      apply(3'b000, 5'h0F, 32'd3,        32'd10,       0, 24'h000000, 1, 4'h7, 4'hF, 32'd7,        4'h2, 4'h2, 0, 0, 32'h0);
      apply(3'b000, 5'h13, 32'hAAAA5555, 32'hAAAA5555, 0, 24'h000000, 1, 4'h9, 4'hE, 32'h0,        4'h4, 4'h2, 0, 0, 32'h0);
      apply(3'b000, 5'h16, 32'h80000000, 32'h80000000, 0, 24'h000000, 1, 4'hB, 4'h0, 32'h0,        4'h7, 4'h4, 0, 0, 32'h0);
      apply(3'b000, 5'h1F, 32'h0,        32'h0,        0, 24'h000001, 1, 4'hF, 4'hE, 32'hFFFFFFFF, 4'h8, 4'h4, 0, 0, 32'h4);
      apply(3'b101, 5'h00, 32'h0,        32'h0,        0, 24'h7FFFFF, 1, 4'hD, 4'h0, 32'h0,        4'h4, 4'h8, 1, 0, 32'h01FFFFFC);
      repeat (2) @(posedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_branch_exec.md
ALU_BRANCH_EXEC -- requirements
Module: alu_branch_exec

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 nreset  input  1  asynchronous, active-low reset.
REQ-003 optype  input  3  instruction bits [27:25].
REQ-004 control  input  5  instruction bits [24:20]; [4:1] DP opcode (or P,U,B,W), [0] S/L; [4] also the branch link bit.
REQ-005 rn  input  32  first operand.
REQ-006 shifter  input  32  shifted second operand.
REQ-007 shifter_carry  input  1  shifter carry-out.
REQ-008 branch_imm  input  24  instruction bits [23:0].
REQ-009 exec_valid  input  1  condition passed and slot not squashed.
REQ-010 alu_opcode  output  4  decoded ALU operation.
REQ-011 should_set  output  4  per-flag write enable {N,Z,C,V}.
REQ-012 alu_out  output  32  ALU result.
REQ-013 alu_flags  output  4  computed flags {N,Z,C,V}.
REQ-014 flags  output  4  registered NZCV state.
REQ-015 ib  output  1  take branch.
REQ-016 bl  output  1  take branch with link.
REQ-017 bv  output  32  branch byte offset.

Function
REQ-018 Only flags is registered; all other outputs are combinational from current inputs and flags.
REQ-019 Opcodes: AND 0, EOR 1, SUB 2, RSB 3, ADD 4, ADC 5, SBC 6, RSC 7, TST 8, TEQ 9, CMP A, CMN B, ORR C, MOV D, BIC E, MVN F.
REQ-020 optype 00x (data processing): alu_opcode = control[4:1].
REQ-021 Data processing with control[0]=1: should_set = 1111 for arithmetic ops (2-7, A, B); 1110 for logical ops (0, 1, 8, 9, C-F).
REQ-022 Data processing with control[0]=0: should_set = 0000.
REQ-023 optype 01x (load/store): alu_opcode = ADD when control[3] (U) = 1, else SUB; should_set = 0000.
REQ-024 Any other optype: alu_opcode = MOV, should_set = 0000.
REQ-025 Arithmetic is 33-bit with carry-in.
REQ-026 Operations: ADD rn+sh; ADC rn+sh+C; SUB rn+~sh+1; SBC rn+~sh+C; RSB sh+~rn+1; RSC sh+~rn+C; CMP as SUB; CMN as ADD.
REQ-027 C = carry-out of bit 31 for all arithmetic ops; for subtract forms this is NOT borrow.
REQ-028 V = signed overflow: operand signs (after inversion) equal and result sign differs.
REQ-029 Logical ops: AND, EOR, ORR, BIC rn&~sh, MOV sh, MVN ~sh; TST as AND, TEQ as EOR.
REQ-030 Logical ops: C = shifter_carry, V = flags[V].
REQ-031 All ops: N = alu_out[31]; Z = (alu_out == 0).
REQ-032 TST, TEQ, CMP and CMN still drive alu_out with the computed value.
REQ-033 Rising clk: for each bit i, flags[i] <= alu_flags[i] when should_set[i] & exec_valid; otherwise flags[i] holds.
REQ-034 Carry-in C for ADC/SBC/RSC is flags[C] (registered value, pre-update).
REQ-035 bv = sign-extended {branch_imm, 2'b00} in 32 bits.
REQ-036 bv is driven regardless of optype.
REQ-037 ib = (optype == 101) & exec_valid.
REQ-038 bl = ib & control[4].
REQ-039 exec_valid = 0 suppresses flag writes and ib/bl; alu_out and alu_flags are still driven.

Reset
REQ-040 nreset low asynchronously clears flags to 0000.
REQ-041 Combinational outputs are unaffected by reset except through flags.
REQ-042 First rising clk after nreset deasserts may update flags.

Verification
REQ-043 SUB, S=1, rn=5, sh=5, exec_valid=1 -> alu_out=0, alu_flags=0110, flags=0110 after clk.
REQ-044 ADD, S=1, rn=0x7FFFFFFF, sh=1 -> alu_out=0x80000000, alu_flags=1001.
REQ-045 ADC, flags C=1, rn=1, sh=1 -> alu_out=3.
REQ-046 MOV, S=1, sh=0, shifter_carry=1, prior V=1 -> flags=0111, V retained.
REQ-047 optype=101, control[4]=1, imm=0xFFFFFE, exec_valid=1 -> ib=1, bl=1, bv=0xFFFFFFF8; same with exec_valid=0 -> ib=0, bl=0, no flag change.
REQ-048 Load/store with U=0, rn=0x100, sh=4 -> alu_out=0xFC, should_set=0000; nreset pulse mid-run -> flags=0000 immediately.
